// File: rtl/simd_exec_monitor_if.sv
// simd_exec_monitor_if: core tap bundle (FSM state, decoded opcode, PC, data strobes, done)
interface simd_exec_monitor_if #(
  parameter int ADDR_W = 10,
  parameter int OPCODE_W = 6
);
  logic [2:0] current_state;
  logic [OPCODE_W-1:0] opcode;
  logic [ADDR_W-1:0] instruction_address;
  logic data_R;
  logic data_W;
  logic done;
  modport master(output current_state, opcode, instruction_address, data_R, data_W, done);
  modport slave(input current_state, opcode, instruction_address, data_R, data_W, done);
endinterface

// File: rtl/simd_exec_monitor.sv
// simd_exec_monitor: run-time checker/counter beside the SIMD core; SIMD_MON_TRACE_EN adds an issue-PC trace buffer
module simd_exec_monitor #(
  parameter int ADDR_W = 10,
  parameter int OPCODE_W = 6,
  parameter int CNT_W = 16,
  parameter int WDOG_CYCLES = 1024,
  parameter int TRACE_DEPTH = 8,
  localparam int TW = TRACE_DEPTH > 1 ? $clog2(TRACE_DEPTH) : 1,
  localparam int WW = $clog2(WDOG_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  simd_exec_monitor_if.slave core,
  input  logic clear,
  output logic [5:0] err_flags,
  output logic err_pulse,
  output logic [2:0] first_err_code,
  output logic [ADDR_W-1:0] first_err_pc,
  output logic [CNT_W-1:0] cnt_instr,
  output logic [CNT_W-1:0] cnt_alu,
  output logic [CNT_W-1:0] cnt_load,
  output logic [CNT_W-1:0] cnt_store,
  output logic [CNT_W-1:0] cnt_ctrl,
  input  logic [TW-1:0] trace_idx,
  output logic [ADDR_W-1:0] trace_pc
);
  localparam logic [2:0] S_IDLE = 3'd0, S_IF = 3'd1, S_ID = 3'd2, S_EX = 3'd3, S_MEM = 3'd4, S_HALT = 3'd5;
  logic [2:0] prev_state;
  logic [2:0] cs;
  logic [WW-1:0] wdog;
  logic [31:0] opc;
  logic legal, issue, run, if_entry;
  logic [5:0] fire;
  logic [2:0] low;
  assign cs = core.current_state;
  assign opc = 32'(core.opcode);
  assign issue = prev_state == S_ID && cs == S_EX;
  assign run = cs != S_IDLE && cs != S_HALT;
  assign if_entry = cs == S_IF && prev_state != S_IF;
  assign fire[0] = !legal;
  assign fire[1] = issue && opc > 46;
  assign fire[2] = run && !if_entry && wdog == WW'(WDOG_CYCLES - 1);
  assign fire[3] = core.data_R && core.data_W;
  assign fire[4] = (core.data_R || core.data_W) && cs != S_MEM;
  assign fire[5] = core.done && cs != S_HALT;
  assign low = fire[0] ? 3'd0 : fire[1] ? 3'd1 : fire[2] ? 3'd2 : fire[3] ? 3'd3 : fire[4] ? 3'd4 : 3'd5;
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic ev, input logic clr);
    logic [CNT_W-1:0] b;
    b = clr ? '0 : c;
    return (ev && !(&b)) ? b + CNT_W'(1) : b;
  endfunction
  // legal successor table of the core FSM; codes 6/7 fall to the default
  always_comb begin
    legal = 1'b0;
    case (prev_state)
      S_IDLE: legal = cs == S_IDLE || cs == S_IF;
      S_IF: legal = cs == S_IF || cs == S_ID;
      S_ID: legal = cs == S_EX;
      S_EX: legal = cs == S_EX || cs == S_MEM || cs == S_IF || cs == S_HALT;
      S_MEM: legal = cs == S_MEM || cs == S_IF || cs == S_HALT;
      S_HALT: legal = cs == S_HALT || cs == S_IDLE;
      default: legal = 1'b0;
    endcase
  end
  // state history, watchdog, sticky flags with first-fault capture, saturating counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_state <= S_IDLE;
      wdog <= '0;
      err_flags <= '0;
      err_pulse <= 1'b0;
      first_err_code <= 3'd7;
      first_err_pc <= '0;
      cnt_instr <= '0;
      cnt_alu <= '0;
      cnt_load <= '0;
      cnt_store <= '0;
      cnt_ctrl <= '0;
    end else begin
      prev_state <= cs;
      wdog <= (clear || !run || if_entry) ? '0 : wdog + WW'(wdog != WW'(WDOG_CYCLES));
      err_flags <= (clear ? 6'd0 : err_flags) | fire;
      err_pulse <= |fire;
      if (|fire && (clear || first_err_code == 3'd7)) begin
        first_err_code <= low;
        first_err_pc <= core.instruction_address;
      end else if (clear) begin
        first_err_code <= 3'd7;
        first_err_pc <= '0;
      end
      cnt_instr <= bump(cnt_instr, issue, clear);
      cnt_alu <= bump(cnt_alu, issue && (opc <= 35 || (opc >= 44 && opc <= 46)), clear);
      cnt_ctrl <= bump(cnt_ctrl, issue && opc >= 36 && opc <= 37, clear);
      cnt_load <= bump(cnt_load, issue && opc >= 38 && opc <= 40, clear);
      cnt_store <= bump(cnt_store, issue && opc >= 41 && opc <= 43, clear);
    end
  end
`ifdef SIMD_MON_TRACE_EN
  logic [ADDR_W-1:0] trace_mem [TRACE_DEPTH];
  logic [TW-1:0] wptr;
  // circular issue-PC log; clear wipes it so unwritten slots read 0, an issue in the clear cycle still lands
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TRACE_DEPTH; i++) trace_mem[i] <= '0;
      wptr <= '0;
    end else begin
      for (int i = 0; i < TRACE_DEPTH; i++) if (clear) trace_mem[i] <= '0;
      if (issue) trace_mem[clear ? '0 : wptr] <= core.instruction_address;
      wptr <= (clear ? '0 : wptr) + TW'(issue);
    end
  end
  assign trace_pc = trace_mem[wptr - TW'(1) - trace_idx];
`else
  logic unused_trace;
  assign unused_trace = ^trace_idx;
  assign trace_pc = '0;
`endif
endmodule
